// File: rtl/float_add_issue_if.sv
// Request, adder-drive and response signal bundle for the float adder issue stage.
// slave = issue stage side, master = requester/adder/consumer side.
interface float_add_issue_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_sub;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      fadd_a;
  logic [31:0]      fadd_b;
  logic             fadd_negate;
  logic             fadd_enable;
  logic [31:0]      fadd_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_tag,
    output req_ready,
    output fadd_a, fadd_b, fadd_negate, fadd_enable,
    input  fadd_out,
    output rsp_valid, rsp_result, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_tag,
    input  req_ready,
    input  fadd_a, fadd_b, fadd_negate, fadd_enable,
    output fadd_out,
    input  rsp_valid, rsp_result, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/float_add_issue.sv
// Queues add/sub requests, issues them to a non-stallable single-cycle adder and returns
// tagged results in order; issue is credit-limited so the 3-entry result buffer never overflows.
module float_add_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  float_add_issue_if.slave    io,
  output logic                busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      fifo_count;
  req_t             head;
  logic             push, issue;

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;

  logic [31:0]      rb_res [3];
  logic [TAG_W-1:0] rb_tag [3];
  logic [1:0]       rb_wr, rb_rd, rb_count;
  logic             rb_push, rb_pop;
  logic [2:0]       inflight;

  assign head         = fifo_mem[rd_ptr];
  assign io.req_ready = (fifo_count != FULL);
  assign push         = io.req_valid && io.req_ready;

  // Results already buffered plus the one in the adder must leave room for this issue.
  assign inflight = {1'b0, rb_count} + {2'b00, s1_valid};
  assign issue    = (fifo_count != '0) && (inflight <= 3'd2);

  assign io.fadd_enable = issue;
  assign io.fadd_a      = issue ? head.a   : 32'h0;
  assign io.fadd_b      = issue ? head.b   : 32'h0;
  assign io.fadd_negate = issue ? head.sub : 1'b0;

  assign rb_push       = s1_valid;
  assign io.rsp_valid  = (rb_count != 2'd0);
  assign rb_pop        = io.rsp_valid && io.rsp_ready;
  assign io.rsp_result = io.rsp_valid ? rb_res[rb_rd] : 32'h0;
  assign io.rsp_tag    = io.rsp_valid ? rb_tag[rb_rd] : '0;

  assign busy = (fifo_count != '0) || s1_valid || (rb_count != 2'd0);

  function automatic logic [1:0] rb_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      rb_wr      <= 2'd0;
      rb_rd      <= 2'd0;
      rb_count   <= 2'd0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(issue);
      s1_valid   <= issue;
      if (issue) s1_tag <= head.tag;
      if (rb_push) rb_wr <= rb_next(rb_wr);
      if (rb_pop)  rb_rd <= rb_next(rb_rd);
      rb_count <= rb_count + {1'b0, rb_push} - {1'b0, rb_pop};
    end
  end

  // Payload storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{a: io.req_a, b: io.req_b, sub: io.req_sub, tag: io.req_tag};
    if (rb_push) begin
      rb_res[rb_wr] <= io.fadd_out;
      rb_tag[rb_wr] <= s1_tag;
    end
  end

  rb_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rb_push && !rb_pop && (rb_count == 2'd3)));
endmodule

// File: tb/tb_float_add_issue.sv
// Directed and random checks of float_add_issue against a queue-based scoreboard and adder model.
module tb_float_add_issue;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  float_add_issue_if #(.TAG_W(TAG_W)) bus ();
  float_add_issue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus.slave), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  req_t iss_q[$];
  logic [31+TAG_W:0] exp_q[$];
  int issued = 0, returned = 0, accepted = 0;
  int en_run = 0, max_en_run = 0, rsp_run = 0, max_rsp_run = 0;
  logic held_vld = 1'b0;
  logic [31:0] held_res;
  logic [TAG_W-1:0] held_tag;
  req_t mon_e;
  logic [31+TAG_W:0] mon_x;

  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic neg);
    return r2sp(sp2r(a) + (neg ? -sp2r(b) : sp2r(b)));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Adder model: output holds junk whenever it was not enabled on the last edge.
  always @(posedge clk)
    bus.fadd_out <= bus.fadd_enable ? fp_add(bus.fadd_a, bus.fadd_b, bus.fadd_negate) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fadd_enable) begin
        chk("credit", 64'((issued - returned) <= 2), 1);
        chk("issue_expected", 64'(iss_q.size() != 0), 1);
        if (iss_q.size() != 0) begin
          mon_e = iss_q.pop_front();
          chk("fadd_a", bus.fadd_a, mon_e.a);
          chk("fadd_b", bus.fadd_b, mon_e.b);
          chk("fadd_negate", bus.fadd_negate, mon_e.sub);
        end
        issued++;
        en_run++;
        if (en_run > max_en_run) max_en_run = en_run;
      end else begin
        en_run = 0;
        chk("idle_operands", 64'((bus.fadd_a | bus.fadd_b) == 0 && !bus.fadd_negate), 1);
      end
      if (held_vld) begin
        chk("rsp_held_valid", bus.rsp_valid, 1);
        chk("rsp_held_stable", {bus.rsp_result, bus.rsp_tag}, {held_res, held_tag});
      end
      held_vld = bus.rsp_valid && !bus.rsp_ready;
      held_res = bus.rsp_result;
      held_tag = bus.rsp_tag;
      if (bus.rsp_valid && bus.rsp_ready) begin
        chk("rsp_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_x = exp_q.pop_front();
          chk("rsp_result", bus.rsp_result, mon_x[31+TAG_W:TAG_W]);
          chk("rsp_tag", bus.rsp_tag, mon_x[TAG_W-1:0]);
        end
        returned++;
        rsp_run++;
        if (rsp_run > max_rsp_run) max_rsp_run = rsp_run;
      end else begin
        rsp_run = 0;
      end
      if (bus.req_valid && bus.req_ready) begin
        iss_q.push_back('{a: bus.req_a, b: bus.req_b, sub: bus.req_sub, tag: bus.req_tag});
        exp_q.push_back({fp_add(bus.req_a, bus.req_b, bus.req_sub), bus.req_tag});
        accepted++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [TAG_W-1:0] t);
    bus.req_a = a;
    bus.req_b = b;
    bus.req_sub = s;
    bus.req_tag = t;
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_req_ready"}, bus.req_ready, 1);
    chk({ph, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({ph, "_rsp_result"}, bus.rsp_result, 0);
    chk({ph, "_rsp_tag"}, bus.rsp_tag, 0);
    chk({ph, "_fadd_enable"}, bus.fadd_enable, 0);
    chk({ph, "_fadd_a"}, bus.fadd_a, 0);
    chk({ph, "_fadd_b"}, bus.fadd_b, 0);
    chk({ph, "_fadd_negate"}, bus.fadd_negate, 0);
    chk({ph, "_busy"}, busy, 0);
  endtask

  task automatic wait_idle(input string ph, input int max);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    chk({ph, "_drain_busy"}, busy, 0);
    chk({ph, "_drain_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int idx, acc0, ret0, n;
    logic take, full_seen;
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    load(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1;
    step();

    // Single add: 1.0 + 2.0, tag 5
    load(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5);
    bus.req_valid = 1;
    chk("add_no_fallthrough", bus.fadd_enable, 0);
    step();
    bus.req_valid = 0;
    chk("add_issue_en", bus.fadd_enable, 1);
    chk("add_issue_a", bus.fadd_a, 32'h3F80_0000);
    chk("add_issue_b", bus.fadd_b, 32'h4000_0000);
    chk("add_issue_neg", bus.fadd_negate, 0);
    step();
    chk("add_one_cycle_en", bus.fadd_enable, 0);
    chk("add_not_yet_valid", bus.rsp_valid, 0);
    step();
    chk("add_rsp_valid", bus.rsp_valid, 1);
    chk("add_rsp_result", bus.rsp_result, 32'h4040_0000);
    chk("add_rsp_tag", bus.rsp_tag, 5);
    step();
    chk("add_busy_clear", busy, 0);

    // Subtract: 3.0 - 1.0
    load(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd9);
    bus.req_valid = 1;
    step();
    bus.req_valid = 0;
    chk("sub_issue_neg", bus.fadd_negate, 1);
    step();
    step();
    chk("sub_rsp_result", bus.rsp_result, 32'h4000_0000);
    wait_idle("sub", 20);

    // Streaming: 8 back-to-back
    max_en_run = 0;
    max_rsp_run = 0;
    for (int i = 0; i < 8; i++) begin
      load(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'(i));
      bus.req_valid = 1;
      chk("stream_req_ready", bus.req_ready, 1);
      step();
    end
    bus.req_valid = 0;
    wait_idle("stream", 40);
    chk("stream_issue_run", max_en_run, 8);
    chk("stream_rsp_run", max_rsp_run, 8);

    // Backpressure: 10 offered with rsp_ready low
    bus.rsp_ready = 0;
    acc0 = accepted;
    ret0 = returned;
    idx = 0;
    load(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'(idx));
    bus.req_valid = 1;
    for (int c = 0; c < 15; c++) begin
      take = bus.req_ready && bus.req_valid;
      step();
      if (take) begin
        idx++;
        if (idx < 10) load(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'(idx));
        else bus.req_valid = 0;
      end
    end
    chk("bp_accepted", idx, 7);
    chk("bp_req_ready", bus.req_ready, 0);
    chk("bp_no_issue", bus.fadd_enable, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    chk("bp_head_tag", bus.rsp_tag, 0);
    bus.rsp_ready = 1;
    full_seen = 0;
    for (int c = 0; c < 60 && idx < 10; c++) begin
      if (bus.fadd_enable && !full_seen) begin
        full_seen = 1;
        chk("full_pop_refuses_push", bus.req_ready, 0);
      end
      take = bus.req_ready && bus.req_valid;
      step();
      if (take) begin
        idx++;
        if (idx < 10) load(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'(idx));
        else bus.req_valid = 0;
      end
    end
    bus.req_valid = 0;
    chk("bp_full_pop_seen", full_seen, 1);
    wait_idle("bp", 60);
    chk("bp_all_accepted", accepted - acc0, 10);
    chk("bp_all_returned", returned - ret0, 10);

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      if (!bus.req_valid && $urandom_range(0, 2) != 0) begin
        load(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)), 4'($urandom));
        bus.req_valid = 1;
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      take = bus.req_valid && bus.req_ready;
      step();
      if (take) bus.req_valid = 0;
    end
    bus.req_valid = 0;
    bus.rsp_ready = 1;
    wait_idle("random", 100);
    chk("random_balance", accepted, returned);

    // Reset mid-flight: build 2 queued, 1 in adder, 2 buffered
    bus.rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      load(rand_fp(), rand_fp(), 1'b0, 4'(i));
      bus.req_valid = 1;
      step();
    end
    bus.rsp_ready = 1;
    load(rand_fp(), rand_fp(), 1'b0, 4'd5);
    step();
    bus.rsp_ready = 0;
    bus.req_valid = 0;
    step();
    chk("mid_busy", busy, 1);
    chk("mid_rsp_valid", bus.rsp_valid, 1);
    #2 rst_n = 0;
    #1 chk_reset_outputs("midreset");
    iss_q.delete();
    exp_q.delete();
    issued = 0;
    returned = 0;
    accepted = 0;
    held_vld = 0;
    @(negedge clk);
    #1 rst_n = 1;
    step();
    load(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd3);
    bus.req_valid = 1;
    bus.rsp_ready = 1;
    step();
    bus.req_valid = 0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("post_reset_rsp_valid", bus.rsp_valid, 1);
    chk("post_reset_tag", bus.rsp_tag, 3);
    chk("post_reset_result", bus.rsp_result, 32'h4000_0000);
    wait_idle("post_reset", 20);
    repeat (5) step();
    chk("post_reset_quiet", bus.rsp_valid, 0);
    chk("post_reset_returned", returned, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
